speed_detector: RTL and testbench
=================================

# speed_detector

- Receive-side counterpart to the team's speed-selectable clock divider.
- Samples an asynchronous slow square wave on the 50 MHz system clock and measures the number of system cycles between successive edges.
- Classifies each measurement against the four divider speed settings and reports a locked speed code.
- Used to verify or auto-detect the speed of a slow clock or tick line arriving from another board or block.

## Interface
Parameters:
- TOL, 1000: match tolerance in cycles (± around each nominal half-period).
- LOCK_COUNT, 2: consecutive matching measurements with the same code required to assert lock (range 1–15).
- TIMEOUT_CYCLES, 50_000_000: cycles without an edge before declaring the input stalled (must be less than 2^26−1).

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_in  in  1  slow input to measure; asynchronous to clk_50MHz.
- half_period  out  26  last measured edge-to-edge interval in cycles.
- meas_valid  out  1  one-cycle pulse when half_period updates with a meaningful value.
- speed_code  out  2  code of the last matched nominal (00 fast … 11 very slow).
- speed_match  out  1  last measurement fell inside one tolerance window.
- locked  out  1  stable speed recognised.
- stalled  out  1  no edge seen for TIMEOUT_CYCLES.

## Operation
- Synchroniser: clk_in passes through two flops; a third flop provides edge detect. Any rising or falling edge counts.
- Interval counter cnt (26 bits): increments every cycle and saturates at 2^26−1. On an edge cycle, half_period is loaded with cnt+1 (saturating) and cnt clears to 0.
- Nominal half-periods: 500001, 2500001, 5000001 and 25000001 for codes 00, 01, 10 and 11. The windows are nominal ±TOL and never overlap at the default TOL.
- Match rule:
  - In window: speed_match=1 and speed_code is set to that code.
  - Outside all windows: speed_match=0 and speed_code holds its previous value.
- States:
  - ACQ (reset value): waits for the first edge. On that edge, go to FIRST with no meas_valid, because the first interval is partial.
  - FIRST: on the next edge, load half_period, pulse meas_valid and go to TRACK.
  - TRACK: every edge loads half_period, pulses meas_valid and updates the match and lock logic.
  - Any state: cnt reaching TIMEOUT_CYCLES goes to ACQ with stalled=1 and locked=0. half_period and speed_code hold.
- stalled clears on the next detected edge.
- Lock counter (4 bits, saturating at LOCK_COUNT):
  - Matched measurement with the same code as the previous match: increment.
  - Match with a new code: set to 1.
  - No match: set to 0.
  - locked = (counter ≥ LOCK_COUNT) in TRACK.
- Simultaneous edge and timeout in the same cycle: the edge wins, with no stall.
- Reset mid-measurement: everything returns to its reset value immediately, and the partial interval is discarded.

## Timing
- Reset values: half_period=0, meas_valid=0, speed_code=00, speed_match=0, locked=0, stalled=0; state ACQ; cnt=0.
- Edge-detect latency: 3 clk_50MHz cycles from the clk_in transition to the edge cycle.
- half_period, meas_valid, speed_match and speed_code update on the clock edge ending the edge cycle. locked updates one cycle later, from the registered match.
- meas_valid is high for exactly 1 cycle per edge in TRACK, plus the FIRST→TRACK edge.
- Measurement accuracy is ±1 cycle of synchroniser jitter, absorbed by TOL.
- stalled asserts on the cycle after cnt reaches TIMEOUT_CYCLES.

## Configuration
- SPEED_DETECT_CHANGE_IRQ_EN defined:
  - Adds input irq_clear (1 bit) and output change_irq (1 bit, reset 0).
  - change_irq sets when locked is high and a match with a different code occurs, or when locked falls.
  - change_irq is sticky until an irq_clear pulse. If set and clear coincide, set wins.
- Not defined: both ports are absent and no related logic is present.

## Test plan
- Ideal divider at setting 00 (toggle every 500001 cycles) → the 2nd edge gives meas_valid with half_period=500001, speed_code=00, speed_match=1; locked=1 one cycle after the 3rd edge (LOCK_COUNT=2).
- Interval 2500001+TOL → match to code 01. Interval 2500001+TOL+1 → speed_match=0, locked drops, speed_code holds 01.
- Locked at 00, then input switches to 5000001 intervals → lock drops at the first new interval and relocks with code 10 after 2 matches. With the macro defined, change_irq=1 until irq_clear.
- TIMEOUT_CYCLES=1000, input held static after lock → stalled=1 and locked=0 at cycle 1001. The next edge clears stalled, goes to FIRST, and produces no meas_valid.
- Edge arriving on the exact timeout cycle → no stall, and half_period=TIMEOUT_CYCLES+1.
- reset asserted mid-interval while locked → all outputs 0 asynchronously. After release, the first two edges produce no lock and the first meas_valid comes on the 2nd edge.

Source files
------------

// File: rtl/speed_detector.sv
// speed_detector: measures edge-to-edge intervals of a slow asynchronous input and matches them against four nominal half-periods.
// Optional sticky speed-change interrupt (irq_clear / change_irq) is built when SPEED_DETECT_CHANGE_IRQ_EN is defined.

module speed_detector #(
  parameter int TOL            = 1000,
  parameter int LOCK_COUNT     = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int NOM_0          = 500_001,
  parameter int NOM_1          = 2_500_001,
  parameter int NOM_2          = 5_000_001,
  parameter int NOM_3          = 25_000_001
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        clk_in,
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
  input  logic        irq_clear,
  output logic        change_irq,
`endif
  output logic [25:0] half_period,
  output logic        meas_valid,
  output logic [1:0]  speed_code,
  output logic        speed_match,
  output logic        locked,
  output logic        stalled
);

  localparam logic [25:0] CNT_MAX     = '1;
  localparam logic [25:0] TIMEOUT_VAL = 26'(TIMEOUT_CYCLES);
  localparam logic [3:0]  LOCK_VAL    = 4'(LOCK_COUNT);

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  function automatic int nominal(input int idx);
    case (idx)
      0:       return NOM_0;
      1:       return NOM_1;
      2:       return NOM_2;
      default: return NOM_3;
    endcase
  endfunction

  logic [2:0]  r_sync;
  logic [2:0]  r_prime;
  logic [25:0] r_cnt;
  logic [1:0]  r_state;
  logic [25:0] r_half_period;
  logic        r_meas_valid;
  logic [1:0]  r_speed_code;
  logic        r_speed_match;
  logic [3:0]  r_lock_cnt;
  logic        r_locked;
  logic        r_stalled;

  logic               w_edge;
  logic               w_meas;
  logic               w_timeout;
  logic [25:0]        w_hp_new;
  logic signed [31:0] w_hp_s;
  logic [3:0]         w_in_win;
  logic               w_any_match;
  logic [1:0]         w_match_code;
  logic [3:0]         w_lock_cnt_next;
  logic               w_locked_next;

  // r_prime masks the bogus edge the synchroniser would show while its
  // stages still hold reset zeros instead of the real input level.
  assign w_edge    = (r_sync[1] ^ r_sync[2]) & r_prime[2];
  assign w_meas    = w_edge && (r_state != ST_ACQ);
  assign w_timeout = !w_edge && (r_cnt == TIMEOUT_VAL);
  assign w_hp_new  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 26'd1;
  assign w_hp_s    = {6'd0, w_hp_new};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      localparam int LO = nominal(gi) - TOL;
      localparam int HI = nominal(gi) + TOL;
      assign w_in_win[gi] = (w_hp_s >= LO) && (w_hp_s <= HI);
    end
  endgenerate

  assign w_any_match = |w_in_win;

  always_comb begin
    w_match_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_in_win[i]) w_match_code = 2'(i);
    end
  end

  always_comb begin
    w_lock_cnt_next = 4'd0;
    if (w_any_match) begin
      if (w_match_code != r_speed_code) w_lock_cnt_next = 4'd1;
      else if (r_lock_cnt >= LOCK_VAL)  w_lock_cnt_next = LOCK_VAL;
      else                              w_lock_cnt_next = r_lock_cnt + 4'd1;
    end
  end

  // Timeout drops lock in the same cycle stalled rises.
  assign w_locked_next = !w_timeout && (r_state == ST_TRACK) && (r_lock_cnt >= LOCK_VAL);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sync        <= 3'd0;
      r_prime       <= 3'd0;
      r_cnt         <= 26'd0;
      r_state       <= ST_ACQ;
      r_half_period <= 26'd0;
      r_meas_valid  <= 1'b0;
      r_speed_code  <= 2'd0;
      r_speed_match <= 1'b0;
      r_lock_cnt    <= 4'd0;
      r_locked      <= 1'b0;
      r_stalled     <= 1'b0;
    end else begin
      r_sync       <= {r_sync[1:0], clk_in};
      r_prime      <= {r_prime[1:0], 1'b1};
      r_meas_valid <= 1'b0;
      r_locked     <= w_locked_next;
      if (w_edge) begin
        r_cnt     <= 26'd0;
        r_stalled <= 1'b0;
        case (r_state)
          ST_ACQ: r_state <= ST_FIRST;
          ST_FIRST, ST_TRACK: begin
            r_state       <= ST_TRACK;
            r_half_period <= w_hp_new;
            r_meas_valid  <= 1'b1;
            r_speed_match <= w_any_match;
            r_lock_cnt    <= w_lock_cnt_next;
            if (w_any_match) r_speed_code <= w_match_code;
          end
          default: r_state <= ST_ACQ;
        endcase
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 26'd1;
        if (w_timeout) begin
          r_state    <= ST_ACQ;
          r_stalled  <= 1'b1;
          r_lock_cnt <= 4'd0;
        end
      end
    end
  end

`ifdef SPEED_DETECT_CHANGE_IRQ_EN
  logic r_change_irq;
  logic w_irq_set;

  assign w_irq_set = r_locked &&
                     ((w_meas && w_any_match && (w_match_code != r_speed_code)) || !w_locked_next);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset)          r_change_irq <= 1'b0;
    else if (w_irq_set) r_change_irq <= 1'b1;
    else if (irq_clear) r_change_irq <= 1'b0;
  end

  assign change_irq = r_change_irq;
`endif

  assign half_period = r_half_period;
  assign meas_valid  = r_meas_valid;
  assign speed_code  = r_speed_code;
  assign speed_match = r_speed_match;
  assign locked      = r_locked;
  assign stalled     = r_stalled;

endmodule

// File: tb/tb_speed_detector.sv
// Bench for speed_detector: directed and random edge intervals checked against an interval-level reference model.
// Reduced nominals/timeout keep the run short; define SPEED_DETECT_CHANGE_IRQ_EN to also check change_irq.

module tb_speed_detector;

  localparam int TOL = 20;
  localparam int LC  = 2;
  localparam int TO  = 3000;
  localparam int N0  = 101;
  localparam int N1  = 301;
  localparam int N2  = 601;
  localparam int N3  = 1201;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_in;
  logic [25:0] half_period;
  logic        meas_valid;
  logic [1:0]  speed_code;
  logic        speed_match;
  logic        locked;
  logic        stalled;
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
  logic        irq_clear;
  logic        change_irq;
`endif

  always #5 clk = ~clk;

  speed_detector #(
    .TOL(TOL), .LOCK_COUNT(LC), .TIMEOUT_CYCLES(TO),
    .NOM_0(N0), .NOM_1(N1), .NOM_2(N2), .NOM_3(N3)
  ) dut (
    .clk_50MHz  (clk),
    .reset      (reset),
    .clk_in     (clk_in),
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    .irq_clear  (irq_clear),
    .change_irq (change_irq),
`endif
    .half_period(half_period),
    .meas_valid (meas_valid),
    .speed_code (speed_code),
    .speed_match(speed_match),
    .locked     (locked),
    .stalled    (stalled)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tracks edges, last measurement, code, lock run length.
  int nom [4];
  int m_edges, m_hp, m_code, m_lock, m_used;
  bit m_meas, m_match, m_locked, m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_hp = 0; m_code = 0; m_lock = 0;
    m_meas = 0; m_match = 0; m_locked = 0; m_irq = 0; m_used = 0;
  endtask

  task automatic model_edge(input int n);
    int  found;
    int  diff;
    bit  prev_locked;
    int  prev_code;
    prev_locked = m_locked;
    prev_code   = m_code;
    m_edges++;
    m_meas = (m_edges >= 2);
    if (m_meas) begin
      m_hp  = n;
      found = -1;
      for (int k = 0; k < 4; k++) begin
        diff = (n > nom[k]) ? n - nom[k] : nom[k] - n;
        if (diff <= TOL && found < 0) found = k;
      end
      if (found >= 0) begin
        m_match = 1;
        if (found == m_code) m_lock = (m_lock + 1 > LC) ? LC : m_lock + 1;
        else                 m_lock = 1;
        m_code = found;
      end else begin
        m_match = 0;
        m_lock  = 0;
      end
      m_locked = (m_lock >= LC);
      if (prev_locked && ((found >= 0 && found != prev_code) || !m_locked)) m_irq = 1;
    end
  endtask

  // One clk_in toggle exactly n system cycles after the previous one.
  task automatic step(input int n);
    bit prev_locked;
    prev_locked = m_locked;
    repeat (n - 4 - m_used) @(posedge clk);
    m_used = 0;
    #2 clk_in = ~clk_in;
    model_edge(n);
    repeat (3) @(posedge clk);
    #1;
    check("meas_valid", meas_valid, m_meas);
    check("locked_latency", locked, prev_locked);
    check("half_period", half_period, m_hp);
    check("speed_code", speed_code, m_code);
    if (m_meas) check("speed_match", speed_match, m_match);
    check("stalled_after_edge", stalled, 0);
    @(posedge clk);
    #1;
    check("meas_valid_pulse", meas_valid, 0);
    check("locked", locked, m_locked);
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    check("change_irq", change_irq, m_irq);
`endif
    $display("edge n=%0d meas=%0b hp=%0d code=%0d match=%0b locked=%0b",
             n, meas_valid, half_period, speed_code, speed_match, locked);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hp"}, half_period, 0);
    check({tag, "_meas"}, meas_valid, 0);
    check({tag, "_code"}, speed_code, 0);
    check({tag, "_match"}, speed_match, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_stalled"}, stalled, 0);
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    check({tag, "_irq"}, change_irq, 0);
`endif
  endtask

  initial begin
    int k, n, reps;
    nom[0] = N0; nom[1] = N1; nom[2] = N2; nom[3] = N3;
    model_reset();
    clk_in = 1'b0;
    reset  = 1'b0;
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    irq_clear = 1'b0;
`endif
    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;

    // Ideal divider at code 00: lock after the third edge.
    repeat (4) step(N0);

    // Window boundaries around code 01.
    step(N1); step(N1);
    step(N1 + TOL);
    step(N1 + TOL + 1);
    step(N1 - TOL);
    step(N1 - TOL - 1);

    // Lock at 00, then switch to code 10.
    repeat (3) step(N0);
    step(N2); step(N2);
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    irq_clear = 1'b1;
    @(posedge clk);
    #1 irq_clear = 1'b0;
    m_irq = 0;
    m_used = 1;
    check("irq_clear", change_irq, 0);
`endif

    // Static input after lock: stall exactly TO+1 cycles after the edge cycle.
    repeat (2) step(N0);
    repeat (TO - 1) @(posedge clk);
    #1 check("stalled_early", stalled, 0);
    @(posedge clk);
    #1;
    check("stalled", stalled, 1);
    check("stall_locked", locked, 0);
    check("stall_hp_hold", half_period, m_hp);
    check("stall_code_hold", speed_code, m_code);
    if (m_locked) m_irq = 1;
    m_edges = 0; m_lock = 0; m_locked = 0;
`ifdef SPEED_DETECT_CHANGE_IRQ_EN
    check("stall_irq", change_irq, m_irq);
    irq_clear = 1'b1;
    @(posedge clk);
    #1 irq_clear = 1'b0;
    m_irq = 0;
`endif
    $display("stall stalled=%0b locked=%0b", stalled, locked);
    step(50);
    step(N0); step(N0);

    // Edge on the exact timeout cycle: edge wins.
    step(TO + 1);

    // Randomised intervals, often repeated so lock is reached.
    for (int t = 0; t < 40; t++) begin
      reps = $urandom_range(1, 3);
      if ($urandom_range(0, 9) < 7) begin
        k = $urandom_range(0, 3);
        n = nom[k] + $urandom_range(0, 2 * TOL + 4) - (TOL + 2);
      end else begin
        n = $urandom_range(5, 1400);
      end
      for (int r = 0; r < reps; r++) step(n);
    end

    // Reset mid-interval while locked.
    repeat (3) step(N0);
    repeat (50) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    repeat (3) step(N0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
